// File: rtl/seq_posi_scan.sv
// rtl/seq_posi_scan.sv - chunked set-bit position scanner with popcount
module seq_posi_scan #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int POS_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] seq,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] posi_reg,
    output logic             found,
    output logic [POS_W-1:0] ones_cnt
);

    localparam int NCH   = WIDTH / STEP;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject parameter sets that cannot be split into whole chunks
    generate
        if ((WIDTH < 2) || (STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_bad_params
            $error("seq_posi_scan: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   sh_q;        // captured word, shifted so the current chunk sits at the scan end
    logic               msb_q;
    logic [IDX_W-1:0]   chunk_idx;
    logic [POS_W-1:0]   cnt_acc;
    logic [POS_W-1:0]   pos_acc;
    logic               pos_latched;

    logic [POS_W-1:0]   chunk_ones;
    logic               hit;
    logic [POS_W-1:0]   hit_pos;
    logic [POS_W-1:0]   cnt_next;
    logic               last_chunk;

    assign in_ready   = (state == IDLE);
    assign last_chunk = (chunk_idx == IDX_W'(NCH - 1));
    assign cnt_next   = cnt_acc + chunk_ones;

    // Examine the current chunk: popcount and first set bit in scan order
    always_comb begin
        int base;
        logic cbit;
        chunk_ones = '0;
        hit        = 1'b0;
        hit_pos    = '0;
        base       = int'(chunk_idx) * STEP;
        for (int i = 0; i < STEP; i++) begin
            cbit       = msb_q ? sh_q[WIDTH-1-i] : sh_q[i];
            chunk_ones = chunk_ones + POS_W'(cbit);
            if (cbit && !hit) begin
                hit     = 1'b1;
                hit_pos = msb_q ? POS_W'(WIDTH - 1 - base - i) : POS_W'(base + i);
            end
        end
    end

    // Control FSM with accumulators and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh_q        <= '0;
            msb_q       <= 1'b0;
            chunk_idx   <= '0;
            cnt_acc     <= '0;
            pos_acc     <= '0;
            pos_latched <= 1'b0;
            out_valid   <= 1'b0;
            posi_reg    <= '0;
            found       <= 1'b0;
            ones_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_q        <= seq;
                        msb_q       <= msb_first;
                        chunk_idx   <= '0;
                        cnt_acc     <= '0;
                        pos_acc     <= '0;
                        pos_latched <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    cnt_acc   <= cnt_next;
                    sh_q      <= msb_q ? (sh_q << STEP) : (sh_q >> STEP);
                    chunk_idx <= chunk_idx + 1'b1;
                    if (!pos_latched && hit) begin
                        pos_acc     <= hit_pos;
                        pos_latched <= 1'b1;
                    end
                    // Scan always covers every chunk; the result is published after the last one
                    if (last_chunk) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        ones_cnt  <= cnt_next;
                        found     <= (cnt_next != '0);
                        if (pos_latched)
                            posi_reg <= pos_acc;
                        else if (hit)
                            posi_reg <= hit_pos;
                        else
                            posi_reg <= POS_W'(WIDTH);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_posi_scan.sv
// tb/tb_seq_posi_scan.sv - scoreboard bench for seq_posi_scan
module tb_seq_posi_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] seq;
    logic        msb_first;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  posi_reg;
    logic        found;
    logic [5:0]  ones_cnt;

    typedef struct {
        logic [5:0] pos;
        logic       f;
        logic [5:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pushed = 0;
    int   popped = 0;
    logic rnd_rdy = 1'b0;

    seq_posi_scan #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seq       (seq),
        .msb_first (msb_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .posi_reg  (posi_reg),
        .found     (found),
        .ones_cnt  (ones_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] s, input logic m);
        exp_t e;
        e.cnt = '0;
        e.pos = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (s[i]) begin
                e.cnt = e.cnt + 6'd1;
                if (m || e.pos == 6'd32) e.pos = 6'(i);
            end
        end
        e.f = (s != 32'd0);
        return e;
    endfunction

    function automatic exp_t mk(input int p, input int f, input int c);
        exp_t e;
        e.pos = 6'(p);
        e.f   = 1'(f);
        e.cnt = 6'(c);
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [31:0] s, input logic m, input logic push, input exp_t e);
        int guard = 0;
        while (!in_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        seq       = s;
        msb_first = m;
        in_valid  = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: every completed output handshake is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                popped++;
                chk("posi_reg", int'(posi_reg), int'(e.pos));
                chk("found",    int'(found),    int'(e.f));
                chk("ones_cnt", int'(ones_cnt), int'(e.cnt));
            end
        end
    end

    // Random consumer backpressure when enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        seq       = '0;
        msb_first = 1'b0;
        out_ready = 1'b0;

        #2;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_posi_reg",  int'(posi_reg),  0);
        chk("rst_found",     int'(found),     0);
        chk("rst_ones_cnt",  int'(ones_cnt),  0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single bit, LSB mode, with latency check
        out_ready = 1'b1;
        send(32'h0000_0100, 1'b0, 1'b1, mk(8, 1, 1));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 7) chk("latency_not_early", int'(out_valid), 0);
            if (k == 8) chk("latency_valid",     int'(out_valid), 1);
        end
        drain();

        // Directed vectors
        send(32'h8000_0001, 1'b1, 1'b1, mk(31, 1, 2));
        send(32'h8000_0001, 1'b0, 1'b1, mk(0, 1, 2));
        send(32'h0000_0000, 1'b0, 1'b1, mk(32, 0, 0));
        send(32'h0000_0000, 1'b1, 1'b1, mk(32, 0, 0));
        send(32'hFFFF_FFFF, 1'b0, 1'b1, mk(0, 1, 32));
        send(32'hFFFF_FFFF, 1'b1, 1'b1, mk(31, 1, 32));
        send(32'h00F0_0000, 1'b1, 1'b1, mk(23, 1, 4));
        send(32'h00F0_0000, 1'b0, 1'b1, mk(20, 1, 4));
        send(32'h0000_0008, 1'b1, 1'b1, mk(3, 1, 1));
        send(32'h4000_0002, 1'b0, 1'b1, mk(1, 1, 2));
        drain();

        // Backpressure in DONE with in_valid held high
        out_ready = 1'b0;
        send(32'h0000_1000, 1'b0, 1'b1, mk(12, 1, 1));
        begin
            int g = 0;
            while (!out_valid && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            chk("hold_reached_done", int'(out_valid), 1);
        end
        seq       = 32'h0000_0002;
        msb_first = 1'b0;
        in_valid  = 1'b1;
        exp_q.push_back(mk(1, 1, 1));
        pushed++;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready",  int'(in_ready),  0);
            chk("hold_posi_reg",  int'(posi_reg),  12);
            chk("hold_ones_cnt",  int'(ones_cnt),  1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle_in_ready",  int'(in_ready),  1);
        chk("release_idle_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("accept_after_idle", int'(in_ready), 0);
        in_valid = 1'b0;
        drain();

        // Reset abort three cycles into a scan
        send(32'h0000_0F00, 1'b0, 1'b0, mk(0, 0, 0));
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready",  int'(in_ready),  1);
        chk("abort_posi_reg",  int'(posi_reg),  0);
        chk("abort_found",     int'(found),     0);
        chk("abort_ones_cnt",  int'(ones_cnt),  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(32'h0000_0010, 1'b0, 1'b1, mk(4, 1, 1));
        drain();

        // Random stream against the reference model
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] s;
            logic        m;
            s = $urandom;
            if (n % 5 == 0) s = s & (32'h1 << $urandom_range(0, 31));
            m = 1'($urandom_range(0, 1));
            send(s, m, 1'b1, model(s, m));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
        drain();
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("results_count", popped, pushed);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_posi_scan.md
SEQ_POSI_SCAN -- requirements
Module: seq_posi_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of the input sequence word; WIDTH >= 2.
REQ-002 SHALL have parameter STEP, default 4: bits examined per scan cycle; WIDTH % STEP == 0, else elaboration error.
REQ-003 SHALL have parameter POS_W, default $clog2(WIDTH)+1: width of the position and count outputs, which hold 0..WIDTH.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; all state in the clk domain.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  seq and msb_first valid.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 seq  input  WIDTH  word to scan; bit 0 = LSB.
REQ-010 msb_first  input  1  0: report lowest set bit; 1: report highest set bit.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 posi_reg  output  POS_W  bit index of reported set bit; WIDTH if none.
REQ-014 found  output  1  at least one bit of seq set.
REQ-015 ones_cnt  output  POS_W  number of set bits in seq.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-017 in_ready SHALL equal (state == IDLE), decoded from the state register only.
REQ-018 IDLE: in_valid=1 at a rising edge SHALL capture seq and msb_first, clear the position/count accumulators, set chunk index 0, and go to SCAN; in_valid=0 SHALL leave the state at IDLE.
REQ-019 SCAN: each cycle SHALL examine one STEP-bit chunk: LSB mode chunk k = bits [k*STEP +: STEP], k ascending; MSB mode chunk k = bits [WIDTH-1-k*STEP -: STEP].
REQ-020 Per chunk, ones_cnt accumulator SHALL add the chunk popcount; the count SHALL NOT saturate, max value WIDTH.
REQ-021 Per chunk, if no position is latched yet and the chunk is nonzero, SHALL latch the absolute index of the lowest set bit (LSB mode) or highest set bit (MSB mode) in that chunk.
REQ-022 Scan SHALL always run exactly WIDTH/STEP cycles, with no early termination, even after a position is latched.
REQ-023 After the last chunk SHALL enter DONE with out_valid=1; posi_reg = latched index or WIDTH if none; found = (ones_cnt != 0).
REQ-024 Latency: word accepted at edge N SHALL make out_valid rise after edge N+WIDTH/STEP.
REQ-025 DONE: outputs SHALL hold stable while out_ready=0; out_valid & out_ready at an edge SHALL return to IDLE and drop out_valid.
REQ-026 in_valid asserted in SCAN or DONE SHALL be ignored; no word accepted in the DONE->IDLE cycle (max throughput one word per WIDTH/STEP+2 cycles).
REQ-027 out_ready outside DONE SHALL have no effect.
REQ-028 posi_reg/found/ones_cnt SHALL be registered and SHALL change only on entry to DONE or on reset.
REQ-029 msb_first SHALL be sampled only at acceptance; changes during SCAN/DONE SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, posi_reg=0, found=0, ones_cnt=0, and clear accumulators and chunk index.
REQ-031 Reset asserted during SCAN or DONE SHALL abort the operation; no result SHALL be presented for the aborted word.
REQ-032 After rst_n deasserts, the first rising edge SHALL be able to accept a word.

Verification (WIDTH=32, STEP=4)
REQ-033 seq=0x0000_0100, msb_first=0, out_ready=1 -> out_valid 8 cycles after acceptance, posi_reg=8, found=1, ones_cnt=1.
REQ-034 seq=0x8000_0001, msb_first=1 -> posi_reg=31, ones_cnt=2; same word with msb_first=0 -> posi_reg=0, ones_cnt=2.
REQ-035 seq=0x0000_0000 -> posi_reg=32, found=0, ones_cnt=0; seq=0xFFFF_FFFF, msb_first=0 -> posi_reg=0, ones_cnt=32.
REQ-036 out_ready held 0 for 5 cycles in DONE, in_valid=1 throughout -> outputs constant, in_ready=0, no word accepted; out_ready=1 -> IDLE next cycle, next word accepted one cycle later.
REQ-037 rst_n pulsed low 3 cycles into SCAN -> out_valid=0, all outputs 0, in_ready=1; a new word 0x0000_0010 then yields posi_reg=4.
REQ-038 Random seq/msb_first stream with random out_ready, checked against a reference model -> every result matches, one result per accepted word, none lost or duplicated.
